// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Definitions shared by the convolution window generator and the convolution
// multiplier that consumes its windows.
//   CONV_BITS        : default pixel width
//   CONV_KERNEL_SIZE : default window edge length
//   pixel_t          : signed pixel type at the default width
//   window_idx()     : bit offset of window element (r,c) inside a packed window
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int CONV_BITS        = 9;
    localparam int CONV_KERNEL_SIZE = 3;

    typedef logic signed [CONV_BITS-1:0] pixel_t;

    // Row 0 is the oldest line and column 0 the oldest column, so the newest
    // pixel lands in the most significant slot.
    function automatic int window_idx(input int r,
                                      input int c,
                                      input int k    = CONV_KERNEL_SIZE,
                                      input int bits = CONV_BITS);
        return (r * k + c) * bits;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// -----------------------------------------------------------------------------
// conv_line_buffer
// One image line of pixel storage, addressed by column. The read port returns
// the value stored before any write in the same cycle, so cascading buffers
// forms a line-to-line delay chain.
// Ports:
//   clk        : system clock
//   wr_en_i    : write wr_data_i at col_i on this edge
//   col_i      : column index (read and write address)
//   wr_data_i  : pixel to store
//   rd_data_o  : pixel currently stored at col_i (old value)
// Storage is deliberately not reset; the row gate in the window generator keeps
// uninitialised contents from ever reaching a window.
// -----------------------------------------------------------------------------
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int BITS      = CONV_BITS,
    parameter int IMG_WIDTH = 32,
    parameter int COL_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [COL_W-1:0] col_i,
    input  logic [BITS-1:0]  wr_data_i,
    output logic [BITS-1:0]  rd_data_o
);

    logic [BITS-1:0] mem_q [IMG_WIDTH];

    assign rd_data_o = mem_q[col_i];

    // Line storage write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[col_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
// Streaming KERNEL_SIZE x KERNEL_SIZE window generator. Takes a raster-order
// pixel stream and emits every fully populated window as one packed word for
// the convolution multiplier (shift_out -> shift_in, window_valid -> out_en).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   pixel_in      : incoming pixel (signed pass-through)
//   pixel_valid   : pixel_in is valid
//   pixel_ready   : pixel can be accepted this cycle
//   frame_start   : accepted pixel is image position (0,0)
//   shift_out     : packed window, element (r,c) at window_idx(r,c)
//   window_valid  : shift_out holds a complete window
//   window_ready  : consumer takes the window this cycle
//   window_count  : completed window handshakes (only with the macro below)
// Build option: define CONV_WINDOW_GEN_CNT_EN to add the window_count port.
// -----------------------------------------------------------------------------
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int BITS        = CONV_BITS,
    parameter int KERNEL_SIZE = CONV_KERNEL_SIZE,
    parameter int IMG_WIDTH   = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [BITS-1:0]                       pixel_in,
    input  logic                                  pixel_valid,
    output logic                                  pixel_ready,
    input  logic                                  frame_start,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] shift_out,
    output logic                                  window_valid,
    input  logic                                  window_ready
`ifdef CONV_WINDOW_GEN_CNT_EN
    ,
    output logic [15:0]                           window_count
`endif
);

    localparam int K     = KERNEL_SIZE;
    localparam int WIN_W = K * K * BITS;
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = $clog2(K);

    localparam logic [COL_W-1:0] COL_ZERO      = COL_W'(0);
    localparam logic [COL_W-1:0] COL_ONE       = COL_W'(1);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO      = ROW_W'(0);
    localparam logic [ROW_W-1:0] ROW_ONE       = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(K - 1);

    // Position counters
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_eff_s;
    logic [ROW_W-1:0] row_eff_s;

    // Handshake
    logic acc_s;
    logic qual_s;

    // Line buffer chain
    logic [BITS-1:0] lb_rd_s [K-1];
    logic [BITS-1:0] lb_wr_s [K-1];

    // Column register, indexed [column][row]; column 0 is the oldest
    logic [BITS-1:0] new_col_s [K];
    logic [BITS-1:0] cols_q [K][K];
    logic [BITS-1:0] cols_d [K][K];
    logic [WIN_W-1:0] win_pack_s;

    // Output window register
    logic [WIN_W-1:0] shift_q, shift_d;
    logic             valid_q, valid_d;

    assign pixel_ready  = !valid_q || window_ready;
    assign acc_s        = pixel_valid && pixel_ready;
    assign shift_out    = shift_q;
    assign window_valid = valid_q;

    // An accepted frame_start pixel is forced to position (0,0).
    always_comb begin
        col_eff_s = col_q;
        row_eff_s = row_q;
        if (acc_s && frame_start) begin
            col_eff_s = COL_ZERO;
            row_eff_s = ROW_ZERO;
        end else begin
            col_eff_s = col_q;
            row_eff_s = row_q;
        end
    end

    // Column/row advance; row saturates because only K-1 past lines matter.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc_s) begin
            if (col_eff_s == COL_LAST) begin
                col_d = COL_ZERO;
                if (row_eff_s == ROW_LAST) begin
                    row_d = row_eff_s;
                end else begin
                    row_d = row_eff_s + ROW_ONE;
                end
            end else begin
                col_d = col_eff_s + COL_ONE;
                row_d = row_eff_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // A window is complete once K-1 earlier lines exist and the column
    // register holds K columns of the current line.
    assign qual_s = acc_s && (row_eff_s == ROW_LAST) && (col_eff_s >= COL_FIRST_WIN);

    // Line buffer chain: lb[0] takes the new pixel, lb[i] takes lb[i-1]'s old value.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            lb_wr_s[i] = '0;
        end
        lb_wr_s[0] = pixel_in;
        for (int i = 1; i < K - 1; i++) begin
            lb_wr_s[i] = lb_rd_s[i-1];
        end
    end

    for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
        conv_line_buffer #(
            .BITS      (BITS),
            .IMG_WIDTH (IMG_WIDTH),
            .COL_W     (COL_W)
        ) u_lb (
            .clk       (clk),
            .wr_en_i   (acc_s),
            .col_i     (col_eff_s),
            .wr_data_i (lb_wr_s[gi]),
            .rd_data_o (lb_rd_s[gi])
        );
    end

    // New right column: oldest line on top (r=0), incoming pixel at the bottom.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            new_col_s[r] = '0;
        end
        new_col_s[K-1] = pixel_in;
        for (int r = 0; r < K - 1; r++) begin
            new_col_s[r] = lb_rd_s[K-2-r];
        end
    end

    // Column register shifts left on every accept, including line starts,
    // so it is already primed when the first window of a line qualifies.
    always_comb begin
        for (int c = 0; c < K; c++) begin
            for (int r = 0; r < K; r++) begin
                cols_d[c][r] = cols_q[c][r];
            end
        end
        if (acc_s) begin
            for (int c = 0; c < K - 1; c++) begin
                for (int r = 0; r < K; r++) begin
                    cols_d[c][r] = cols_q[c+1][r];
                end
            end
            for (int r = 0; r < K; r++) begin
                cols_d[K-1][r] = new_col_s[r];
            end
        end else begin
            for (int c = 0; c < K; c++) begin
                for (int r = 0; r < K; r++) begin
                    cols_d[c][r] = cols_q[c][r];
                end
            end
        end
    end

    // Pack the post-shift column register into the window word.
    always_comb begin
        win_pack_s = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_pack_s[window_idx(r, c, K, BITS) +: BITS] = cols_d[c][r];
            end
        end
    end

    // Window output: load on a qualifying accept (back-to-back with a handshake),
    // drop after a handshake, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        shift_d = shift_q;
        if (qual_s) begin
            valid_d = 1'b1;
            shift_d = win_pack_s;
        end else if (window_ready) begin
            valid_d = 1'b0;
            shift_d = shift_q;
        end else begin
            valid_d = valid_q;
            shift_d = shift_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= COL_ZERO;
            row_q   <= ROW_ZERO;
            valid_q <= 1'b0;
            shift_q <= '0;
            for (int c = 0; c < K; c++) begin
                for (int r = 0; r < K; r++) begin
                    cols_q[c][r] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            shift_q <= shift_d;
            cols_q  <= cols_d;
        end
    end

`ifdef CONV_WINDOW_GEN_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        hs_s;

    assign hs_s         = valid_q && window_ready;
    assign window_count = cnt_q;

    // Handshake counter; a frame start restarts it, counting a coincident handshake.
    always_comb begin
        cnt_d = cnt_q;
        if (acc_s && frame_start) begin
            cnt_d = hs_s ? 16'd1 : 16'd0;
        end else if (hs_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Handshake counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
// Directed bench for conv_window_gen with a 4-pixel-wide image (pixel value =
// row*4 + col). Vector tables cover raster fill, line wrap and a mid-frame
// frame_start; hand-written sequences cover backpressure and async reset.
// -----------------------------------------------------------------------------
module tb_conv_window_gen;

    localparam int BITS  = 9;
    localparam int KS    = 3;
    localparam int W     = 4;
    localparam int WIN_W = KS * KS * BITS;

    logic             clk;
    logic             rst_n;
    logic [BITS-1:0]  pixel_in;
    logic             pixel_valid;
    logic             pixel_ready;
    logic             frame_start;
    logic [WIN_W-1:0] shift_out;
    logic             window_valid;
    logic             window_ready;
`ifdef CONV_WINDOW_GEN_CNT_EN
    logic [15:0]      window_count;
`endif

    conv_window_gen #(
        .BITS        (BITS),
        .KERNEL_SIZE (KS),
        .IMG_WIDTH   (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .frame_start  (frame_start),
        .shift_out    (shift_out),
        .window_valid (window_valid),
        .window_ready (window_ready)
`ifdef CONV_WINDOW_GEN_CNT_EN
        ,
        .window_count (window_count)
`endif
    );

    typedef struct {
        logic            pv;
        logic            fs;
        logic [BITS-1:0] pix;
        logic            wr;
        logic            exp_v;
        int              exp_tl;
    } vec_t;

    vec_t raster_tbl [17];
    vec_t fs_tbl     [19];

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_win(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Window whose top-left image pixel has value tl (image values = row*4+col).
    function automatic logic [WIN_W-1:0] make_win(input int tl);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < KS; r++) begin
            for (int c = 0; c < KS; c++) begin
                w[(r*KS+c)*BITS +: BITS] = BITS'(tl + r*W + c);
            end
        end
        return w;
    endfunction

    // Window from an explicit element list in (r,c) order.
    function automatic logic [WIN_W-1:0] pack9(input int e [9]);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) begin
            w[i*BITS +: BITS] = BITS'(e[i]);
        end
        return w;
    endfunction

    task automatic run_vec(input vec_t v, input string tag, input int idx);
        pixel_valid  = v.pv;
        frame_start  = v.fs;
        pixel_in     = v.pix;
        window_ready = v.wr;
        @(posedge clk);
        #1;
        chk_bit($sformatf("%s[%0d] valid", tag, idx), window_valid, v.exp_v);
        if (v.exp_v) begin
            chk_win($sformatf("%s[%0d] window", tag, idx), shift_out, make_win(v.exp_tl));
        end
    endtask

    task automatic idle_inputs();
        pixel_valid  = 1'b0;
        frame_start  = 1'b0;
        pixel_in     = '0;
        window_ready = 1'b1;
    endtask

    initial begin
        vec_t v;
        int   tl_after [16];

        // Raster frame 0..15: windows one cycle after pixels 10, 11, 14, 15.
        for (int p = 0; p < 16; p++) begin
            raster_tbl[p] = '{1'b1, (p == 0), BITS'(p), 1'b1, 1'b0, 0};
        end
        raster_tbl[10].exp_v = 1'b1; raster_tbl[10].exp_tl = 0;
        raster_tbl[11].exp_v = 1'b1; raster_tbl[11].exp_tl = 1;
        raster_tbl[14].exp_v = 1'b1; raster_tbl[14].exp_tl = 4;
        raster_tbl[15].exp_v = 1'b1; raster_tbl[15].exp_tl = 5;
        raster_tbl[16] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 0};

        // Two stray pixels with row saturated, then a restarted frame.
        fs_tbl[0] = '{1'b1, 1'b0, BITS'(0), 1'b1, 1'b0, 0};
        fs_tbl[1] = '{1'b1, 1'b0, BITS'(1), 1'b1, 1'b0, 0};
        for (int i = 0; i < 17; i++) begin
            fs_tbl[i+2] = raster_tbl[i];
        end

        for (int p = 0; p < 16; p++) begin
            tl_after[p] = -1;
        end
        tl_after[10] = 0; tl_after[11] = 1; tl_after[14] = 4; tl_after[15] = 5;

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        window_ready = 1'b0;
        #12;
        chk_bit("reset valid", window_valid, 1'b0);
        chk_win("reset window", shift_out, '0);
        chk_bit("reset ready", pixel_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Raster fill and line wrap
        for (int i = 0; i < 17; i++) begin
            run_vec(raster_tbl[i], "raster", i);
        end
`ifdef CONV_WINDOW_GEN_CNT_EN
        chk16("count after frame", window_count, 16'd4);
`endif

        // frame_start mid-frame
        for (int i = 0; i < 19; i++) begin
            run_vec(fs_tbl[i], "fstart", i);
        end

        // Backpressure: hold the first window for 5 cycles
        for (int p = 0; p <= 10; p++) begin
            v = '{1'b1, (p == 0), BITS'(p), 1'b1, (p == 10), 0};
            run_vec(v, "bp_fill", p);
        end
        pixel_valid  = 1'b1;
        frame_start  = 1'b0;
        pixel_in     = BITS'(11);
        window_ready = 1'b0;
        #1;
        chk_bit("bp ready low", pixel_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_bit($sformatf("bp hold[%0d] valid", i), window_valid, 1'b1);
            chk_win($sformatf("bp hold[%0d] window", i), shift_out, pack9('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
            chk_bit($sformatf("bp hold[%0d] ready", i), pixel_ready, 1'b0);
        end
        for (int p = 11; p < 16; p++) begin
            v = '{1'b1, 1'b0, BITS'(p), 1'b1, (tl_after[p] >= 0), tl_after[p]};
            run_vec(v, "bp_drain", p);
            if (p == 14) begin
                chk_win("wrap window 14", shift_out, pack9('{4, 5, 6, 8, 9, 10, 12, 13, 14}));
            end
        end
        chk_win("last window", shift_out, pack9('{5, 6, 7, 9, 10, 11, 13, 14, 15}));
        v = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 0};
        run_vec(v, "bp_idle", 0);

        // Asynchronous reset while a window is pending
        for (int p = 0; p <= 10; p++) begin
            v = '{1'b1, (p == 0), BITS'(p), 1'b1, (p == 10), 0};
            run_vec(v, "rst_fill", p);
        end
        pixel_valid  = 1'b0;
        window_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_bit("async rst valid", window_valid, 1'b0);
        chk_win("async rst window", shift_out, '0);
        chk_bit("async rst ready", pixel_ready, 1'b1);
`ifdef CONV_WINDOW_GEN_CNT_EN
        chk16("async rst count", window_count, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            run_vec(raster_tbl[i], "restart", i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule
